seq_divider: RTL and testbench
==============================

# seq_divider

Multi-cycle unsigned restoring divider: the inverse of the existing shift-based multiply path. It accepts a dividend/divisor pair on a start pulse, produces one quotient bit per clock, and presents quotient and remainder with a one-cycle done pulse. It sits beside the add/subtract datapath in the arithmetic unit and serves operations that a constant right shift cannot cover, i.e. arbitrary divisors.

## Interface
Parameters:
- WIDTH, 8, operand, quotient and remainder width (≥2)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  reset, synchronous and active-low
- start  input  1  request; sampled only while ready=1
- dividend  input  WIDTH  numerator, latched on accept
- divisor  input  WIDTH  denominator, latched on accept
- ready  output  1  idle and able to accept start
- busy  output  1  iteration in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  result, held until next accept
- remainder  output  WIDTH  result, held until next accept
- div_by_zero  output  1  set with done when divisor was 0; held like results

## Operation
- States: IDLE, CALC, DONE.
- IDLE: ready=1. On start=1:
  - latch operands;
  - clear the partial remainder (WIDTH+1 bits);
  - load the quotient shift register with the dividend;
  - clear the iteration counter (ceil(log2(WIDTH+1)) bits);
  - go to CALC. quotient, remainder and div_by_zero are not cleared on accept.
- CALC, each cycle, counter i = 0..WIDTH-1:
  - t = {rem[WIDTH-1:0], q[WIDTH-1]};
  - d = t − {0, divisor}, WIDTH+1 bits;
  - if d[WIDTH]=0: rem←d, q←{q[WIDTH-2:0],1}; else: rem←t, q←{q[WIDTH-2:0],0}.
  - After iteration WIDTH-1: go to DONE, register quotient=q and remainder=rem[WIDTH-1:0], done=1.
- DONE: lasts exactly one cycle, then returns to IDLE. start is ignored in DONE.
- start while busy or in DONE: ignored. Latched operands and results are unaffected.
- Operand inputs may change freely after the accept edge.
- Reset (rst_n=0 at an edge), in any state including mid-CALC:
  - next state IDLE;
  - ready=1;
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0;
  - counter and partial remainder cleared.

## Timing
- Accept edge = edge 0.
- CALC occupies edges 1..WIDTH. done is high in the cycle after edge WIDTH; latency is WIDTH cycles.
- ready falls after edge 0 and rises after edge WIDTH+1. Back-to-back throughput: one result per WIDTH+2 cycles.
- busy=1 exactly while state=CALC.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- SEQ_DIVIDER_DIV0_CHECK_EN defined:
  - divisor=0 at accept skips CALC and goes straight to DONE, so done appears after edge 1;
  - results: quotient = all ones, remainder = dividend, div_by_zero=1.
  - div_by_zero clears on the next accept with a nonzero divisor.
- Undefined:
  - no early exit; a zero divisor runs the full WIDTH iterations;
  - the restoring algorithm naturally yields quotient = all ones and remainder = dividend;
  - div_by_zero is tied to 0.

## Structure
- Package seq_divider_pkg holds:
  - the state enum (IDLE, CALC, DONE);
  - the default width constant DIV_WIDTH_DEFAULT=8.
- Sub-module div_step: purely combinational, one iteration. Inputs: rem, q MSB, divisor. Outputs: next rem and quotient bit. It is instantiated once in the top level, which owns the FSM, counter and registers.

## Test plan
- 100/7, WIDTH=8 -> quotient=14, remainder=2; done exactly 8 cycles after the accept edge; busy high for 8 cycles.
- 255/1 and 5/9 back-to-back, start pulsed as soon as ready returns -> 255 r0, then 0 r5; second accept occurs 10 cycles after the first.
- 200/0:
  - with SEQ_DIVIDER_DIV0_CHECK_EN -> done 1 cycle after accept, quotient=255, remainder=200, div_by_zero=1;
  - without -> done after 8 cycles, same values, div_by_zero=0.
- start pulsed mid-CALC with 9/3 while computing 100/7 -> ignored; the result is still 14 r2; ready stays 0 until after DONE.
- rst_n low at CALC iteration 4 -> the next cycle shows state IDLE, ready=1, all other outputs 0; a following 50/6 gives 8 r2 with normal latency.
- Randomized sweep of ≥1000 pairs with nonzero divisor -> quotient×divisor+remainder == dividend and remainder < divisor for every result.

Source files
------------

// File: rtl/seq_divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
package seq_divider_pkg;

    localparam int unsigned DIV_WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract, restore on borrow.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_i,
    input  logic             q_msb_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic [WIDTH:0]   rem_o,
    output logic             q_bit_o
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] d;
    // The stored partial remainder is always below the divisor, so its top bit stays zero.
    logic           unused_rem_msb;

    assign unused_rem_msb = rem_i[WIDTH];

    always_comb begin
        t       = {rem_i[WIDTH-1:0], q_msb_i};
        d       = t - {1'b0, divisor_i};
        q_bit_o = ~d[WIDTH];
        rem_o   = d[WIDTH] ? t : d;
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle unsigned restoring divider, one quotient bit per clock.
// Optional early exit on a zero divisor: SEQ_DIVIDER_DIV0_CHECK_EN.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] dividend_i,
    input  logic [WIDTH-1:0] divisor_i,
    output logic             ready_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] quotient_o,
    output logic [WIDTH-1:0] remainder_o,
    output logic             div_by_zero_o
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remd_q, remd_d;
    logic [WIDTH:0]   step_rem;
    logic             step_bit;
`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
    logic             dbz_q, dbz_d;
`endif

    div_step #(
        .WIDTH(WIDTH)
    ) u_div_step (
        .rem_i    (rem_q),
        .q_msb_i  (q_q[WIDTH-1]),
        .divisor_i(dsr_q),
        .rem_o    (step_rem),
        .q_bit_o  (step_bit)
    );

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        q_d     = q_q;
        dsr_d   = dsr_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remd_d  = remd_q;
`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    dsr_d   = divisor_i;
                    rem_d   = '0;
                    q_d     = dividend_i;
                    cnt_d   = '0;
                    state_d = StCalc;
`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
                    if (divisor_i != '0) begin
                        dbz_d = 1'b0;
                    end
`endif
                end
            end
            StCalc: begin
`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
                // q_q still holds the untouched dividend on the first CALC cycle.
                if (dsr_q == '0) begin
                    quot_d  = '1;
                    remd_d  = q_q;
                    dbz_d   = 1'b1;
                    state_d = StDone;
                end else
`endif
                begin
                    rem_d = step_rem;
                    q_d   = {q_q[WIDTH-2:0], step_bit};
                    cnt_d = cnt_q + CntW'(1);
                    if (cnt_q == CntW'(WIDTH - 1)) begin
                        quot_d  = {q_q[WIDTH-2:0], step_bit};
                        remd_d  = step_rem[WIDTH-1:0];
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            rem_q   <= '0;
            q_q     <= '0;
            dsr_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            remd_q  <= '0;
`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            q_q     <= q_d;
            dsr_q   <= dsr_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remd_q  <= remd_d;
`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign ready_o     = (state_q == StIdle);
    assign busy_o      = (state_q == StCalc);
    assign done_o      = (state_q == StDone);
    assign quotient_o  = quot_q;
    assign remainder_o = remd_q;
`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
    assign div_by_zero_o = dbz_q;
`else
    assign div_by_zero_o = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: stimulus pushes expected results, a monitor pops on done.
module tb_seq_divider;

`ifdef SEQ_DIVIDER_DIV0_CHECK_EN
    localparam bit Div0En = 1'b1;
`else
    localparam bit Div0En = 1'b0;
`endif

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       ready;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   prev_acc = 0;
    exp_t sb[$];
    exp_t mon_e;
    logic [15:0] recon;

    seq_divider #(
        .WIDTH(8)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .dividend_i   (dividend),
        .divisor_i    (divisor),
        .ready_o      (ready),
        .busy_o       (busy),
        .done_o       (done),
        .quotient_o   (quotient),
        .remainder_o  (remainder),
        .div_by_zero_o(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compare every presented result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("quotient", {24'd0, quotient}, {24'd0, mon_e.q});
                check("remainder", {24'd0, remainder}, {24'd0, mon_e.r});
                check("div_by_zero", {31'd0, div_by_zero}, {31'd0, mon_e.dbz});
                if (mon_e.b != 8'd0) begin
                    recon = 16'(quotient) * 16'(mon_e.b) + 16'(remainder);
                    check("reconstruct", {16'd0, recon}, {24'd0, mon_e.a});
                    check("rem_lt_divisor", {31'd0, remainder < mon_e.b}, 32'd1);
                end
            end
        end
    end

    task automatic wait_ready();
        int k;
        k = 0;
        @(negedge clk);
        while (!ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    // Issue one division, push its expectation, and check latency and busy length.
    task automatic run(input logic [7:0] a, input logic [7:0] b);
        int   n;
        int   bc;
        int   lat_exp;
        exp_t e;
        wait_ready();
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.a   = a;
        e.b   = b;
        e.q   = (b == 8'd0) ? 8'hFF : a / b;
        e.r   = (b == 8'd0) ? a : a % b;
        e.dbz = Div0En && (b == 8'd0);
        sb.push_back(e);
        @(posedge clk);
        #1;
        prev_acc = last_acc;
        last_acc = cyc;
        start    = 1'b0;
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        check("ready_after_accept", {31'd0, ready}, 32'd0);
        if (b != 8'd0) check("dbz_clear_on_accept", {31'd0, div_by_zero}, 32'd0);
        bc = int'(busy);
        n  = 0;
        while (n < 40 && !done) begin
            @(posedge clk);
            #1;
            n++;
            if (!done) bc += int'(busy);
        end
        lat_exp = (Div0En && b == 8'd0) ? 1 : 8;
        check("latency", n, lat_exp);
        check("busy_cycles", bc, lat_exp);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        exp_t e;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = 8'd0;
        divisor  = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_quotient", {24'd0, quotient}, 32'd0);
        check("rst_remainder", {24'd0, remainder}, 32'd0);
        check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;

        run(8'd100, 8'd7);
        run(8'd255, 8'd1);
        run(8'd5, 8'd9);
        check("b2b_accept_gap", last_acc - prev_acc, 10);
        run(8'd200, 8'd0);
        run(8'd12, 8'd4);

        // start pulsed mid-CALC must be ignored
        wait_ready();
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        e.a = 8'd100; e.b = 8'd7; e.q = 8'd14; e.r = 8'd2; e.dbz = 1'b0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd9;
        divisor  = 8'd3;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            check("ready_low_in_calc", {31'd0, ready}, 32'd0);
            @(posedge clk);
            #1;
            n++;
        end
        check("mid_done_seen", {31'd0, done}, 32'd1);
        check("ready_low_in_done", {31'd0, ready}, 32'd0);
        @(posedge clk);
        #1;
        check("ready_after_done", {31'd0, ready}, 32'd1);

        // reset during CALC iteration 4
        wait_ready();
        dividend = 8'd100;
        divisor  = 8'd7;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_quotient", {24'd0, quotient}, 32'd0);
        check("midrst_remainder", {24'd0, remainder}, 32'd0);
        check("midrst_dbz", {31'd0, div_by_zero}, 32'd0);
        rst_n = 1'b1;
        run(8'd50, 8'd6);

        run(8'd0, 8'd5);
        run(8'd255, 8'd255);
        run(8'd254, 8'd255);
        run(8'd1, 8'd0);
        run(8'd128, 8'd2);

        for (int i = 0; i < 1000; i++) begin
            run(8'($urandom_range(0, 255)), 8'($urandom_range(1, 255)));
        end

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_empty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
